// File: rtl/sum_collect.sv
// Collects CC consecutive W-bit result slices into one N-bit word and offers it on a valid/ready output.
// Optional macro SUM_COLLECT_OVF_EN keeps the final carry; without it out_carry is tied to 0.
module sum_collect #(
  parameter int N  = 1024,
  parameter int CC = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_start,
  input  logic [N/CC-1:0]                       in_slice,
  input  logic                                  in_carry,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N-1:0]                          out_data,
  output logic                                  out_carry,
  output logic [(CC > 1 ? $clog2(CC) : 1)-1:0]  slice_idx
);

  localparam int W     = N / CC;
  localparam int IDX_W = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CC - 1);

  if (N % CC != 0) begin : g_bad_width
    $error("sum_collect: N must be a multiple of CC");
  end

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, wr_idx;
  logic [N-1:0]     data_q, data_d;
  logic             accept, transfer, last;

  // Output decode: a completed word stalls input until it is taken.
  always_comb begin : output_logic
    out_valid = (state_q == HOLD);
    in_ready  = !out_valid || out_ready;
    out_data  = data_q;
    slice_idx = idx_q;
  end

  always_comb begin : next_state_logic
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
    accept   = in_valid && in_ready;
    transfer = out_valid && out_ready;
    wr_idx   = in_start ? '0 : idx_q;
    last     = (wr_idx == LAST_IDX);
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;

    if (accept) begin
      for (int k = 0; k < CC; k++) begin
        if (wr_idx == IDX_W'(k)) data_d[k*W +: W] = in_slice;
      end
      idx_d = last ? '0 : wr_idx + 1'b1;
    end

    // In HOLD an accept implies a transfer; the new slice opens the next word.
    case (state_q)
      COLLECT: if (accept && last) state_d = HOLD;
      HOLD:    if (transfer) state_d = (accept && last) ? HOLD : COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin : state_register
    // NOTE: sequential state uses non-blocking '<='; the word register is reset too because its reset value of 0 is observable.
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef SUM_COLLECT_OVF_EN
  logic carry_q;

  // Only the carry that arrives with the final slice is the word's carry.
  always_ff @(posedge clk) begin : carry_register
    if (rst)                 carry_q <= 1'b0;
    else if (accept && last) carry_q <= in_carry;
  end

  assign out_carry = carry_q;
`else
  logic carry_unused;

  assign carry_unused = in_carry;
  assign out_carry    = 1'b0;
`endif

endmodule

// File: doc/sum_collect.md
# sum_collect

Downstream stage of the multi-cycle adder `sum`. It accepts the N/CC-bit result slices that `sum` emits one per clock, least-significant slice first. It assembles CC consecutive slices into a full N-bit word and presents that word, with the final carry, on a valid/ready output handshake. The result is then available to the next garbled-circuit stage as a single wide operand.

## Interface
- `N`, 1024, full word width in bits; must be a multiple of `CC`
- `CC`, 4, slices per word (W = N/CC bits per slice); `CC`=1 is legal
- `clk`  input  1  clock; all state changes on rising edge
- `rst`  input  1  synchronous, active-high reset, sampled on rising edge of `clk`
- `in_valid`  input  1  `in_slice` and `in_carry` are valid this cycle
- `in_ready`  output  1  block can accept a slice this cycle
- `in_start`  input  1  accepted slice is slice 0 of a new word; discards any partial word
- `in_slice`  input  W  result slice from `sum`
- `in_carry`  input  1  running carry out of `sum`; only the value on the last slice is kept
- `out_valid`  output  1  `out_data`/`out_carry` hold a complete word
- `out_ready`  input  1  consumer takes the word this cycle
- `out_data`  output  N  assembled word; slice k occupies bits [(k+1)W-1 : kW]
- `out_carry`  output  1  carry out of the full N-bit addition
- `slice_idx`  output  clog2(CC) (min 1)  index the next accepted slice will fill

## Operation
- Accept: `in_valid && in_ready`. Transfer: `out_valid && out_ready`.
- `in_ready` = `!out_valid || out_ready`, so a completed word stalls input until it is taken.
- States:
  - COLLECT: `out_valid`=0; accepted slices are written at `slice_idx`.
  - HOLD: `out_valid`=1; waiting for the transfer.
- COLLECT, accept with `slice_idx` < CC-1: write the slice, then `slice_idx`+1.
- COLLECT, accept with `slice_idx` = CC-1:
  - write the slice and latch `in_carry` into `out_carry`;
  - `slice_idx` returns to 0; go to HOLD.
- `in_start`=1 on any accept forces that slice to index 0, then continues as above. Earlier partial slices are discarded; their bits in `out_data` are don't-care until overwritten.
- HOLD, transfer without accept: go to COLLECT.
- HOLD, transfer with accept in the same cycle:
  - the accepted slice is slice 0 of the next word, written at index 0;
  - go to COLLECT, or stay in HOLD if CC=1.
- `out_data` bits not yet written for the current word are undefined while `out_valid`=0. Consumers sample only on a transfer.
- `in_carry` on non-final slices is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_carry`=0, `slice_idx`=0, state COLLECT; therefore `in_ready`=1.
- `rst` has priority over every other input in the same cycle.
- `rst` asserted mid-word drops the partial word. `rst` asserted in HOLD drops the completed word without a transfer.
- Latency: `out_valid` rises the cycle after the CC-th accept. With continuous `in_valid` and `out_ready` held at 1, throughput is one word per CC cycles with no bubbles.
- Gaps (`in_valid`=0) between slices are allowed and do not reset `slice_idx`.
- `out_data` and `out_carry` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `SUM_COLLECT_OVF_EN` defined: `out_carry` is registered as described.
- Not defined:
  - `out_carry` is tied to 0 and `in_carry` is unused;
  - no flop is generated for the carry.
- All other behaviour is identical in both builds.

## Test plan
- Word assembly: N=16, CC=4; accept 0x1,0x2,0x3,0x4 on consecutive cycles with `out_ready`=1, `in_carry`=1 on the last slice.
  -> One cycle after the 4th accept: `out_valid`=1, `out_data`=0x4321, `out_carry`=1 (0 without `SUM_COLLECT_OVF_EN`).
- Backpressure: hold `out_ready`=0 after a word completes.
  -> `in_ready`=0; `out_data` stable for 5 cycles.
  -> Raise `out_ready`; transfer occurs and `in_ready`=1 in the same cycle.
- Back-to-back: stream 8 slices with `out_ready`=1.
  -> Two words arrive, `out_valid` pulses 1 cycle each, 4 cycles apart, with no dropped slice.
- Restart: accept 0xA,0xB, then `in_start`=1 with 0x1, followed by 0x2,0x3,0x4.
  -> Output word 0x4321; `slice_idx` sequence 0,1,2,0→1,2,3,0.
- Reset: assert `rst` after 2 slices, then again while in HOLD.
  -> Next cycle all outputs equal their reset values; the next 4 slices form a fresh word.
- CC=1, N=8: accept 0x5A then 0x3C, with a transfer in the same cycle as the second accept.
  -> `out_data`=0x5A, then 0x3C on the next cycle; `out_valid` stays 1.
